// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-side types for the memory subsystem.
//   word_t      : 32-bit machine word
//   ramstate_t  : status reported by the single-ported RAM each cycle
//                 (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : states of the instruction/data memory arbiter
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported RAM between the instruction and data sides of the
// datapath. Data requests win over instruction requests. Each RAM access is
// run to completion, then a one-cycle ihit/dhit pulse is returned together
// with registered load data. Accesses that stall too long are aborted and
// flagged on the sticky memerr output.
//
// Ports:
//   CLK, nRST              clock (rising edge), async active-low reset
//   imemREN, imemaddr      instruction read request and word address
//   dmemREN, dmemWEN       data read / write request (write wins if both)
//   dmemaddr, dmemstore    data address and write value
//   ihit, dhit             one-cycle completion pulses
//   imemload, dmemload     registered instruction word / data read value
//   memerr                 sticky RAM error or timeout flag
//   ramREN, ramWEN         RAM read / write enables
//   ramaddr, ramstore      RAM address and write data
//   ramload, ramstate      RAM read data and status
// ----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      imemREN,
    input  word_t     imemaddr,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     imemload,
    output word_t     dmemload,
    output logic      memerr,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t       state;
    logic             isData;
    logic             isWrite;
    word_t            addrReg;
    word_t            storeReg;
    logic [CNT_W-1:0] waitCnt;
    logic             inAccess;
    logic             lastWait;

    // The RAM only ever sees the latched address/data, so requester changes
    // mid-access cannot disturb a transaction in flight. Strobes are decoded
    // from the state register, which means they fall the moment nRST asserts.
    always_comb begin
        inAccess = (state == DACC) || (state == IACC);
        lastWait = (waitCnt == CNT_W'(TIMEOUT - 1));
        ramREN   = inAccess && !isWrite;
        ramWEN   = inAccess && isWrite;
        ramaddr  = addrReg;
        ramstore = storeReg;
    end

    // Main sequencer. IDLE grants data before instruction; the access states
    // wait for ACCESS, ERROR or the timeout; RESP lasts exactly one cycle and
    // carries the hit pulse. Requests are deliberately ignored in RESP so the
    // requester has the hit edge to withdraw before IDLE samples again.
    // The wait counter holds the number of cycles already spent in the
    // access state, so an abort happens after TIMEOUT strobe cycles.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            isData   <= 1'b0;
            isWrite  <= 1'b0;
            addrReg  <= '0;
            storeReg <= '0;
            waitCnt  <= '0;
            imemload <= '0;
            dmemload <= '0;
            memerr   <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmemREN || dmemWEN) begin
                        isData   <= 1'b1;
                        isWrite  <= dmemWEN;
                        addrReg  <= dmemaddr;
                        storeReg <= dmemstore;
                        waitCnt  <= '0;
                        state    <= DACC;
                    end else if (imemREN) begin
                        isData   <= 1'b0;
                        isWrite  <= 1'b0;
                        addrReg  <= imemaddr;
                        waitCnt  <= '0;
                        state    <= IACC;
                    end
                end
                DACC, IACC: begin
                    if (ramstate == ACCESS) begin
                        if (!isData) begin
                            imemload <= ramload;
                        end else if (!isWrite) begin
                            dmemload <= ramload;
                        end
                        ihit  <= !isData;
                        dhit  <= isData;
                        state <= RESP;
                    end else if ((ramstate == ERROR) || lastWait) begin
                        memerr <= 1'b1;
                        ihit   <= !isData;
                        dhit   <= isData;
                        state  <= RESP;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (TIMEOUT = 4). A table of directed
// transactions, hand-written sequences for priority and mid-access reset,
// then random transactions checked against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic      CLK;
    logic      nRST;
    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;
    logic      memerr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramState;

    int testsRun;
    int testsFailed;

    word_t mImem;
    word_t mDmem;
    bit    mErr;

    typedef struct {
        string name;
        int    kind;
        word_t addr;
        word_t store;
        int    busy;
        bit    giveErr;
        word_t data;
        int    expStrobes;
        word_t expImem;
        word_t expDmem;
        bit    expErr;
    } vec_t;

    vec_t vecs[7];

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemload  (imemload),
        .dmemload  (dmemload),
        .memerr    (memerr),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramState)
    );

    // Free-running 10-time-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: every check steps testsRun and, on a
    // mismatch, testsFailed.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Hold reset across a couple of edges and release it on a falling edge.
    task automatic applyReset();
        @(negedge CLK);
        nRST = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        ramState = FREE;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        mImem = '0; mDmem = '0; mErr = 1'b0;
    endtask

    // One complete transaction. kind: 0 instr read, 1 data read, 2 data
    // write, 3 data read+write (treated as write). The RAM model answers
    // BUSY for 'busy' strobe cycles, then ACCESS (or ERROR if giveErr).
    // The request is withdrawn and the live address/data scrambled right
    // after the grant edge, so the arbiter must work from latched values.
    task automatic applyStimulus(input string name, input int kind, input word_t addr,
                                 input word_t store, input int busy, input bit giveErr,
                                 input word_t data, input int expStrobes,
                                 input word_t expImem, input word_t expDmem, input bit expErr);
        int       strobes  = 0;
        int       badDir   = 0;
        int       badAddr  = 0;
        int       badStore = 0;
        logic [1:0] hitCode = 2'b00;
        bit       seen     = 1'b0;
        bit       isWr     = (kind >= 2);
        bit       isDat    = (kind != 0);
        @(negedge CLK);
        imemREN   = (kind == 0);
        dmemREN   = (kind == 1) || (kind == 3);
        dmemWEN   = (kind >= 2);
        if (kind == 0) imemaddr = addr; else dmemaddr = addr;
        dmemstore = store;
        ramState  = FREE;
        @(posedge CLK);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
            imemaddr = $urandom; dmemaddr = $urandom; dmemstore = $urandom;
            if (ihit || dhit) begin
                seen     = 1'b1;
                hitCode  = {ihit, dhit};
                ramState = FREE;
            end else if (ramREN || ramWEN) begin
                if ((ramWEN !== isWr) || (ramREN !== !isWr)) badDir++;
                if (ramaddr !== addr) badAddr++;
                if (isWr && (ramstore !== store)) badStore++;
                ramState = (strobes < busy) ? BUSY : (giveErr ? ERROR : ACCESS);
                ramload  = (ramState == ACCESS) ? data : word_t'($urandom);
                strobes++;
            end else begin
                ramState = FREE;
            end
        end
        checkOutput({name, ".hitSeen"}, 32'(seen), 32'd1);
        checkOutput({name, ".hitKind"}, 32'(hitCode), isDat ? 32'd1 : 32'd2);
        checkOutput({name, ".strobes"}, 32'(strobes), 32'(expStrobes));
        checkOutput({name, ".strobeDir"}, 32'(badDir), 32'd0);
        checkOutput({name, ".ramaddr"}, 32'(badAddr), 32'd0);
        checkOutput({name, ".ramstore"}, 32'(badStore), 32'd0);
        checkOutput({name, ".imemload"}, imemload, expImem);
        checkOutput({name, ".dmemload"}, dmemload, expDmem);
        checkOutput({name, ".memerr"}, 32'(memerr), 32'(expErr));
        @(negedge CLK);
        checkOutput({name, ".pulseEnd"}, {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    endtask

    // Raise both requests together: data must be served first, then the
    // still-pending instruction read.
    task automatic priorityTest();
        int    dCyc = -1;
        int    iCyc = -1;
        word_t firstAddr = '1;
        bit    gotFirst = 1'b0;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h400;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        ramState = FREE;
        @(posedge CLK);
        for (int c = 0; c < 40 && iCyc < 0; c++) begin
            @(negedge CLK);
            dmemREN = 1'b0;
            if (dhit && dCyc < 0) dCyc = c;
            if (ihit) begin
                iCyc = c;
                imemREN = 1'b0;
            end
            if (ramREN) begin
                if (!gotFirst) begin
                    firstAddr = ramaddr;
                    gotFirst  = 1'b1;
                end
                ramState = ACCESS;
                ramload  = (ramaddr == 32'h100) ? 32'h0D0D0D0D : 32'h11001100;
            end else begin
                ramState = FREE;
            end
        end
        checkOutput("prio.firstAddr", firstAddr, 32'h100);
        checkOutput("prio.dhitSeen", 32'(dCyc >= 0), 32'd1);
        checkOutput("prio.ihitAfter", 32'((iCyc >= 0) && (iCyc - dCyc >= 2)), 32'd1);
        checkOutput("prio.dmemload", dmemload, 32'h0D0D0D0D);
        checkOutput("prio.imemload", imemload, 32'h11001100);
    endtask

    // Assert nRST between clock edges while a data read is stalled; the RAM
    // strobes and all registered outputs must clear without an edge.
    task automatic resetMidAccess();
        @(negedge CLK);
        dmemREN = 1'b1; dmemaddr = 32'h500;
        ramState = FREE;
        @(posedge CLK);
        @(negedge CLK);
        dmemREN = 1'b0;
        ramState = BUSY;
        checkOutput("rst.strobeBefore", 32'(ramREN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        checkOutput("rst.strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        checkOutput("rst.hits", {30'd0, ihit, dhit}, 32'd0);
        checkOutput("rst.memerr", 32'(memerr), 32'd0);
        checkOutput("rst.loads", imemload | dmemload, 32'd0);
        checkOutput("rst.ramaddr", ramaddr, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        ramState = FREE;
        mImem = '0; mDmem = '0; mErr = 1'b0;
    endtask

    initial begin
        int    kind;
        int    busy;
        bit    giveErr;
        word_t addr;
        word_t store;
        word_t data;
        int    expStrobes;
        bit    failedAcc;

        testsRun = 0;
        testsFailed = 0;
        nRST = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        ramload = '0; ramState = FREE;
        mImem = '0; mDmem = '0; mErr = 1'b0;

        vecs[0] = '{"iread",    0, 32'h40,  32'h0,        2, 1'b0, 32'h8C220004, 3, 32'h8C220004, 32'h0,        1'b0};
        vecs[1] = '{"dwrite",   2, 32'h200, 32'hDEADBEEF, 0, 1'b0, 32'hAAAAAAAA, 1, 32'h8C220004, 32'h0,        1'b0};
        vecs[2] = '{"dread",    1, 32'h300, 32'h0,        1, 1'b0, 32'h12345678, 2, 32'h8C220004, 32'h12345678, 1'b0};
        vecs[3] = '{"dboth",    3, 32'h304, 32'hCAFEF00D, 0, 1'b0, 32'hBBBBBBBB, 1, 32'h8C220004, 32'h12345678, 1'b0};
        vecs[4] = '{"ilastcyc", 0, 32'h44,  32'h0,        3, 1'b0, 32'h44444444, 4, 32'h44444444, 32'h12345678, 1'b0};
        vecs[5] = '{"derror",   1, 32'h308, 32'h0,        1, 1'b1, 32'h55555555, 2, 32'h44444444, 32'h12345678, 1'b1};
        vecs[6] = '{"isticky",  0, 32'h48,  32'h0,        0, 1'b0, 32'h66666666, 1, 32'h66666666, 32'h12345678, 1'b1};

        #3;
        checkOutput("reset.outputs", {26'd0, ihit, dhit, memerr, ramREN, ramWEN, 1'b0}, 32'd0);
        checkOutput("reset.loads", imemload | dmemload | ramaddr | ramstore, 32'd0);
        applyReset();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].name, vecs[i].kind, vecs[i].addr, vecs[i].store,
                          vecs[i].busy, vecs[i].giveErr, vecs[i].data, vecs[i].expStrobes,
                          vecs[i].expImem, vecs[i].expDmem, vecs[i].expErr);
        end

        priorityTest();
        resetMidAccess();

        applyStimulus("fresh",   1, 32'h600, 32'h0, 0, 1'b0, 32'h5A5A5A5A, 1, 32'h0,        32'h5A5A5A5A, 1'b0);
        applyStimulus("timeout", 1, 32'h604, 32'h0, 9, 1'b0, 32'h77777777, 4, 32'h0,        32'h5A5A5A5A, 1'b1);
        applyStimulus("errKept", 0, 32'h608, 32'h0, 1, 1'b0, 32'h88888888, 2, 32'h88888888, 32'h5A5A5A5A, 1'b1);

        // Random transactions against the transaction-level model: a
        // request completes after min(busy+1, TIMEOUT) strobe cycles, fails
        // if the RAM errors or never reaches ACCESS within TIMEOUT cycles,
        // and only successful reads update the matching load register.
        applyReset();
        for (int n = 0; n < 40; n++) begin
            kind    = int'($urandom_range(0, 3));
            busy    = int'($urandom_range(0, 5));
            giveErr = ($urandom_range(0, 9) == 0);
            addr    = $urandom;
            store   = $urandom;
            data    = $urandom;
            expStrobes = (busy < TO) ? busy + 1 : TO;
            failedAcc  = (busy >= TO) || giveErr;
            if (!failedAcc) begin
                if (kind == 0) mImem = data;
                else if (kind == 1) mDmem = data;
            end
            mErr = mErr | failedAcc;
            applyStimulus("rand", kind, addr, store, busy, giveErr, data, expStrobes,
                          mImem, mDmem, mErr);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
